// File: rtl/mem_stage_sram.sv
// mem_stage_sram: ARM pipeline memory stage with an internal word-addressed
// SRAM model. A load or store freezes upstream for WAIT_CYCLES cycles. The
// result is then registered into the MEM/WB pipeline register.
//
// Ports:
//   clk, rst                        clock (rising edge), async active-high reset
//   exe_wb_en, exe_mem_r_en,
//   exe_mem_w_en                    control bits from the execute stage
//   exe_alu_res                     effective byte address, or the ALU result
//   exe_val_rm                      store data
//   exe_dest                        destination register
//   stall                           combinational freeze request to IF/ID/EXE
//   wb_wb_en, wb_mem_r_en,
//   wb_alu_res, wb_mem_data,
//   wb_dest                         registered MEM/WB outputs
module mem_stage_sram #(
  parameter int DEPTH_WORDS = 64,   // power of two
  parameter int ADDR_BASE   = 1024, // byte address of word 0
  parameter int WAIT_CYCLES = 4     // total stall cycles per access, >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exe_wb_en,
  input  logic        exe_mem_r_en,
  input  logic        exe_mem_w_en,
  input  logic [31:0] exe_alu_res,
  input  logic [31:0] exe_val_rm,
  input  logic [3:0]  exe_dest,
  output logic        stall,
  output logic        wb_wb_en,
  output logic        wb_mem_r_en,
  output logic [31:0] wb_alu_res,
  output logic [31:0] wb_mem_data,
  output logic [3:0]  wb_dest
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(WAIT_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     rdata_q;

  logic            wb_wb_en_q, wb_mem_r_en_q;
  logic [31:0]     wb_alu_res_q, wb_mem_data_q;
  logic [3:0]      wb_dest_q;

  logic            req;
  logic            is_load;
  logic            is_store;
  logic            last_edge;
  logic [AW-1:0]   widx;

  // A store wins when both enables are set.
  assign req      = exe_mem_r_en | exe_mem_w_en;
  assign is_store = exe_mem_w_en;
  assign is_load  = exe_mem_r_en & ~exe_mem_w_en;

  // Word index: strip the base, drop the byte offset and wrap modulo depth.
  assign widx = AW'((exe_alu_res - 32'(ADDR_BASE)) >> 2);

  // The final ACCESS edge is where the array is actually touched.
  assign last_edge = (state_q == ACCESS) && (cnt_q == CW'(WAIT_CYCLES - 1));

  // Next-state and stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = CW'(1);
        end
      end
      ACCESS: begin
        stall = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (last_edge) begin
          state_d = DONE;
          cnt_d   = '0;
        end
      end
      DONE: begin
        // The request is still on the inputs because upstream was frozen;
        // returning to IDLE without looking at it avoids a second access.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset must drop the freeze immediately, even with a request present.
    if (rst) begin
      stall = 1'b0;
    end
  end

  // Data array and read latch are not reset.
  always_ff @(posedge clk) begin
    if (last_edge && is_store) begin
      mem_q[widx] <= exe_val_rm;
    end
    if (last_edge && is_load) begin
      rdata_q <= mem_q[widx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wb_wb_en_q    <= 1'b0;
      wb_mem_r_en_q <= 1'b0;
      wb_alu_res_q  <= '0;
      wb_mem_data_q <= '0;
      wb_dest_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall) begin
        // Bubble: kill the write-back, keep the data fields.
        wb_wb_en_q    <= 1'b0;
        wb_mem_r_en_q <= 1'b0;
      end else begin
        wb_wb_en_q    <= exe_wb_en;
        wb_mem_r_en_q <= is_load;
        wb_alu_res_q  <= exe_alu_res;
        wb_dest_q     <= exe_dest;
        if ((state_q == DONE) && is_load) begin
          wb_mem_data_q <= rdata_q;
        end
      end
    end
  end

  assign wb_wb_en    = wb_wb_en_q;
  assign wb_mem_r_en = wb_mem_r_en_q;
  assign wb_alu_res  = wb_alu_res_q;
  assign wb_mem_data = wb_mem_data_q;
  assign wb_dest     = wb_dest_q;

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  localparam int DEPTH = 64;
  localparam int BASE  = 1024;
  localparam int W     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        exe_wb_en = 1'b0;
  logic        exe_mem_r_en = 1'b0;
  logic        exe_mem_w_en = 1'b0;
  logic [31:0] exe_alu_res = '0;
  logic [31:0] exe_val_rm = '0;
  logic [3:0]  exe_dest = '0;
  logic        stall;
  logic        wb_wb_en;
  logic        wb_mem_r_en;
  logic [31:0] wb_alu_res;
  logic [31:0] wb_mem_data;
  logic [3:0]  wb_dest;

  mem_stage_sram #(
    .DEPTH_WORDS(DEPTH),
    .ADDR_BASE  (BASE),
    .WAIT_CYCLES(W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .exe_wb_en   (exe_wb_en),
    .exe_mem_r_en(exe_mem_r_en),
    .exe_mem_w_en(exe_mem_w_en),
    .exe_alu_res (exe_alu_res),
    .exe_val_rm  (exe_val_rm),
    .exe_dest    (exe_dest),
    .stall       (stall),
    .wb_wb_en    (wb_wb_en),
    .wb_mem_r_en (wb_mem_r_en),
    .wb_alu_res  (wb_alu_res),
    .wb_mem_data (wb_mem_data),
    .wb_dest     (wb_dest)
  );

  always #5 clk = ~clk;

  int          n_asserts = 0;
  int          n_fail = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_mdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_mem_w_en = 1'b0;
    exe_alu_res = '0; exe_val_rm = '0; exe_dest = '0;
  endtask

  // Present one instruction (called at posedge+1), follow it through the
  // stall window and check what lands in MEM/WB one edge after the stall ends.
  task automatic do_op(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] rm,
                       input logic [3:0] dest);
    logic [31:0] off;
    int idx;
    int nst;
    int exp_st;
    exe_wb_en = wb; exe_mem_r_en = r; exe_mem_w_en = w;
    exe_alu_res = alu; exe_val_rm = rm; exe_dest = dest;
    #1;
    nst = 0;
    while (stall === 1'b1 && nst < W + 3) begin
      nst++;
      @(posedge clk); #1;
      chk("bubble_wb_en", {31'b0, wb_wb_en}, 32'd0);
    end
    exp_st = (r || w) ? W : 0;
    chk("stall_cycles", nst, exp_st);
    @(posedge clk); #1;
    off = alu - BASE;
    idx = int'((off / 4) % DEPTH);
    if (w) model_mem[idx] = rm;
    else if (r) exp_mdata = model_mem[idx];
    chk("wb_wb_en", {31'b0, wb_wb_en}, {31'b0, wb});
    chk("wb_mem_r_en", {31'b0, wb_mem_r_en}, {31'b0, r & ~w});
    chk("wb_alu_res", wb_alu_res, alu);
    chk("wb_dest", {28'b0, wb_dest}, {28'b0, dest});
    chk("wb_mem_data", wb_mem_data, exp_mdata);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_stall"}, {31'b0, stall}, 32'd0);
    chk({pfx, "_wb_en"}, {31'b0, wb_wb_en}, 32'd0);
    chk({pfx, "_mem_r_en"}, {31'b0, wb_mem_r_en}, 32'd0);
    chk({pfx, "_alu_res"}, wb_alu_res, 32'd0);
    chk({pfx, "_mem_data"}, wb_mem_data, 32'd0);
    chk({pfx, "_dest"}, {28'b0, wb_dest}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] v;
    int kind;

    // Asynchronous reset asserted mid-cycle with a load request present.
    repeat (2) @(posedge clk);
    exe_mem_r_en = 1'b1; exe_alu_res = 32'd1028;
    #3 rst = 1'b1;
    #1 chk_reset_outputs("rst_async");
    set_idle();
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    exp_mdata = '0;

    // ALU pass-through.
    do_op(1'b1, 1'b0, 1'b0, 32'h0000_0025, 32'h0, 4'd3);

    // Store then load at 1028.
    do_op(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 4'd0);
    do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd5);

    // Wrap past the top of memory, then read back at the base.
    do_op(1'b0, 1'b0, 1'b1, BASE + 4 * DEPTH, 32'h11, 4'd0);
    do_op(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'd7);

    // Both enables: store wins.
    do_op(1'b1, 1'b1, 1'b1, 32'd1040, 32'hCAFE_0001, 4'd2);
    do_op(1'b1, 1'b1, 1'b0, 32'd1042, 32'h0, 4'd9);

    // Back-to-back loads.
    do_op(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd4);
    do_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd6);

    // Fill every word so random loads always hit known data.
    for (int i = 0; i < DEPTH; i++) begin
      do_op(1'b0, 1'b0, 1'b1, BASE + 4 * i, $urandom, 4'd0);
    end

    // Random mix of ALU ops, stores, loads and store+load collisions.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 3);
      a = BASE + 4 * $urandom_range(0, 2 * DEPTH - 1) + $urandom_range(0, 3);
      v = $urandom;
      case (kind)
        0: do_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, v, 32'h0, 4'($urandom_range(0, 15)));
        1: do_op(1'b0, 1'b0, 1'b1, a, v, 4'($urandom_range(0, 15)));
        2: do_op(1'b1, 1'b1, 1'b0, a, 32'h0, 4'($urandom_range(0, 15)));
        default: do_op(1'b1, 1'b1, 1'b1, a, v, 4'($urandom_range(0, 15)));
      endcase
    end

    // Reset while a store is in ACCESS with cnt==2: no write may happen.
    do_op(1'b0, 1'b0, 1'b1, 32'd1048, 32'h1234_5678, 4'd0);
    exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_mem_w_en = 1'b1;
    exe_alu_res = 32'd1048; exe_val_rm = 32'h8765_4321; exe_dest = 4'd0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_reset_outputs("rst_access");
    exp_mdata = '0;
    set_idle();
    @(posedge clk); #3 rst = 1'b0;
    #1 chk("rst_release_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    do_op(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd8);
    set_idle();

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
Name: mem_stage_sram

Overview:
- Memory stage of the ARM pipeline. Sits directly downstream of the execute stage and consumes its outputs: ALU result, Rm value, destination and control bits.
- Performs data-memory loads and stores against an internal word-addressed SRAM model with a fixed multi-cycle access latency.
- Raises a stall so the upstream IF/ID/EXE registers freeze during an access.
- Registers its results into the MEM/WB pipeline register consumed by writeback.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words in the data memory; power of two.
- ADDR_BASE, 1024, byte address that maps to word 0.
- WAIT_CYCLES, 4, total stall cycles per memory access; must be >= 2.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- exe_wb_en  in  1  instruction writes the register file.
- exe_mem_r_en  in  1  load request.
- exe_mem_w_en  in  1  store request.
- exe_alu_res  in  32  effective byte address, or the ALU result for non-memory ops.
- exe_val_rm  in  32  store data.
- exe_dest  in  4  destination register.
- stall  out  1  freeze request to IF/ID/EXE registers and the hazard unit; combinational.
- wb_wb_en  out  1  registered writeback enable.
- wb_mem_r_en  out  1  registered load flag; selects wb_mem_data over wb_alu_res.
- wb_alu_res  out  32  registered ALU result.
- wb_mem_data  out  32  registered load data.
- wb_dest  out  4  registered destination.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, cnt=0, stall=0, all wb_* outputs=0. The memory array is not reset.
- req = exe_mem_r_en | exe_mem_w_en.
- Store priority: if both enables are set, the op is a store and the registered wb_mem_r_en is 0.
- Address: widx = ((exe_alu_res - ADDR_BASE) >> 2) truncated to log2(DEPTH_WORDS) bits. Out-of-range addresses wrap modulo DEPTH_WORDS; no error is flagged. Low 2 address bits are ignored.
- FSM states IDLE, ACCESS, DONE; cnt has width ceil(log2(WAIT_CYCLES))+1.
  - IDLE: if req, stall=1 and the next state is ACCESS with cnt<=1. Otherwise stall=0 and the op passes through.
  - ACCESS: stall=1; cnt increments each edge. On the edge where cnt==WAIT_CYCLES-1:
    - a store writes mem[widx]<=exe_val_rm;
    - a load latches rdata<=mem[widx];
    - the next state is DONE.
  - DONE: stall=0. The request is still present on the inputs because upstream was frozen; DONE must not restart an access. Next state is IDLE.
- Stall timing: total stall = WAIT_CYCLES cycles per memory op (1 in IDLE plus WAIT_CYCLES-1 in ACCESS). Exactly one write occurs per store.
- Upstream inputs are guaranteed stable while stall=1.
- MEM/WB register behaviour on every rising edge:
  - If stall=1: insert a bubble. wb_wb_en<=0 and wb_mem_r_en<=0; wb_alu_res, wb_mem_data and wb_dest hold.
  - Else: wb_wb_en<=exe_wb_en, wb_mem_r_en<=exe_mem_r_en&~exe_mem_w_en, wb_alu_res<=exe_alu_res, wb_dest<=exe_dest. wb_mem_data<=rdata when in DONE for a load, otherwise it holds.
- Non-memory op latency: 1 cycle, no stall.
- Memory op latency: results are visible on wb_* one edge after the DONE cycle, i.e. WAIT_CYCLES+1 edges after the request first appears.
- Back-to-back memory ops: after DONE, IDLE sees the next request and starts a fresh access. There is one non-stalled cycle (DONE) between accesses.
- Reset mid-access: the FSM returns to IDLE with no write performed, provided reset asserts before the final ACCESS edge.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> stall=0 and all wb_*=0 immediately, without waiting for a clock edge.
- ALU pass-through: exe_wb_en=1, alu_res=0x0000_0025, dest=3, no mem -> stall stays 0; next edge wb_wb_en=1, wb_alu_res=0x25, wb_dest=3, wb_mem_r_en=0.
- Store then load, WAIT_CYCLES=4:
  - Store to 1028 with val_rm=0xDEADBEEF -> stall high exactly 4 cycles; wb_wb_en=0 throughout.
  - Load from 1028, dest=5 -> stall high 4 cycles; then wb_mem_r_en=1, wb_mem_data=0xDEADBEEF, wb_dest=5.
- Wrap and priority:
  - Store 0x11 to ADDR_BASE+4*DEPTH_WORDS -> load from ADDR_BASE returns 0x11.
  - Both enables set -> the op is treated as a store and wb_mem_r_en=0.
- Back-to-back loads: two consecutive loads -> stall pattern 1111 0 1111, both wb_mem_data values correct, no duplicate writeback.
- Reset during ACCESS of a store (cnt=2): assert rst -> after release, a load from that address returns the old value; stall=0 on release.
